// File: rtl/noc_traffic_node.sv
// NoC traffic node: bursts fixed-format packets out of tx and checks
// packets arriving on rx for destination, ordering and framing.
module noc_traffic_node #(
   parameter int X_ID     = 0,
   parameter int Y_ID     = 0,
   parameter int ID_X_W   = 4,
   parameter int ID_Y_W   = 4,
   parameter int DATA_W   = 32,
   parameter int PKT_LEN  = 4,
   parameter int NUM_PKTS = 8,
   parameter int GAP_CYC  = 0
) (
   input  logic              noc_clk,
   input  logic              noc_rst,
   input  logic              send_start,
   input  logic [ID_X_W-1:0] dst_x,
   input  logic [ID_Y_W-1:0] dst_y,
   input  logic              rx_stall,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [DATA_W-1:0] rx_flit,
   input  logic              rx_is_header,
   input  logic              rx_is_tail,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [DATA_W-1:0] tx_flit,
   output logic              tx_is_header,
   output logic              tx_is_tail,
   output logic              send_busy,
   output logic              send_done,
   output logic [15:0]       tx_pkt_cnt,
   output logic [15:0]       rx_pkt_cnt,
   output logic [15:0]       rx_err_cnt,
   output logic              rx_err
);

   localparam int HW = 2 * (ID_X_W + ID_Y_W) + 16;
   localparam int EW = (DATA_W > 32) ? DATA_W : 32;
   localparam logic [15:0] LAST = 16'(PKT_LEN - 1);
   localparam logic [15:0] NPK = 16'(NUM_PKTS);
   localparam logic [31:0] GAPM1 =
      (GAP_CYC > 0) ? 32'(GAP_CYC - 1) : 32'd0;
   localparam logic [ID_X_W-1:0] SX = ID_X_W'(X_ID);
   localparam logic [ID_Y_W-1:0] SY = ID_Y_W'(Y_ID);

   if (DATA_W < HW) begin : g_bad_w
      $error("DATA_W too small for header layout");
   end
   if (PKT_LEN < 1 || PKT_LEN > 65535) begin : g_bad_len
      $error("PKT_LEN out of range 1..65535");
   end
   if (NUM_PKTS < 1 || NUM_PKTS > 65535) begin : g_bad_np
      $error("NUM_PKTS out of range 1..65535");
   end
   if (GAP_CYC < 0) begin : g_bad_gap
      $error("GAP_CYC must be non-negative");
   end

   function automatic logic [DATA_W-1:0] hdr_f(
      input logic [ID_X_W-1:0] dx,
      input logic [ID_Y_W-1:0] dy,
      input logic [15:0]       s
   );
      logic [DATA_W-1:0] f;
      f = '0;
      f[HW-1:0] = {s, SY, SX, dy, dx};
      return f;
   endfunction

   function automatic logic [DATA_W-1:0] body_f(
      input logic [15:0] s,
      input logic [15:0] i
   );
      logic [EW-1:0] e;
      e = '0;
      e[31:0] = {s, i};
      return e[DATA_W-1:0];
   endfunction

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_BODY, S_GAP, S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic              vld_q, vld_d;
   logic [DATA_W-1:0] flit_q, flit_d;
   logic              hdr_q, hdr_d;
   logic              tail_q, tail_d;
   logic [15:0]       seq_q, seq_d;
   logic [15:0]       idx_q, idx_d;
   logic [15:0]       pcnt_q, pcnt_d;
   logic [31:0]       gap_q, gap_d;
   logic [ID_X_W-1:0] dx_q, dx_d;
   logic [ID_Y_W-1:0] dy_q, dy_d;
   logic              fire;
   logic [15:0]       idx_n;
   logic [15:0]       seq_n;
   logic [15:0]       pcnt_n;

   always_comb begin
      state_d = state_q;
      vld_d   = vld_q;
      flit_d  = flit_q;
      hdr_d   = hdr_q;
      tail_d  = tail_q;
      seq_d   = seq_q;
      idx_d   = idx_q;
      pcnt_d  = pcnt_q;
      gap_d   = gap_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      fire    = vld_q & tx_ready;
      idx_n   = idx_q + 16'd1;
      seq_n   = seq_q + 16'd1;
      pcnt_n  = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (send_start) begin
               state_d = S_HDR;
               dx_d    = dst_x;
               dy_d    = dst_y;
               seq_d   = '0;
               idx_d   = '0;
               pcnt_d  = '0;
               vld_d   = 1'b1;
               flit_d  = hdr_f(dst_x, dst_y, 16'd0);
               hdr_d   = 1'b1;
               tail_d  = (PKT_LEN == 1);
            end
         end
         S_HDR, S_BODY: begin
            if (fire && idx_q == LAST) begin
               pcnt_d = pcnt_n;
               seq_d  = seq_n;
               idx_d  = '0;
               vld_d  = 1'b0;
               flit_d = '0;
               hdr_d  = 1'b0;
               tail_d = 1'b0;
               if (pcnt_n == NPK) begin
                  state_d = S_DONE;
               end else if (GAP_CYC == 0) begin
                  state_d = S_HDR;
                  vld_d   = 1'b1;
                  flit_d  = hdr_f(dx_q, dy_q, seq_n);
                  hdr_d   = 1'b1;
                  tail_d  = (PKT_LEN == 1);
               end else begin
                  state_d = S_GAP;
                  gap_d   = GAPM1;
               end
            end else if (fire) begin
               state_d = S_BODY;
               idx_d   = idx_n;
               flit_d  = body_f(seq_q, idx_n);
               hdr_d   = 1'b0;
               tail_d  = (idx_n == LAST);
            end
         end
         S_GAP: begin
            if (gap_q == 32'd0) begin
               state_d = S_HDR;
               vld_d   = 1'b1;
               flit_d  = hdr_f(dx_q, dy_q, seq_q);
               hdr_d   = 1'b1;
               tail_d  = (PKT_LEN == 1);
            end else begin
               gap_d = gap_q - 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         state_q <= S_IDLE;
         vld_q   <= 1'b0;
         flit_q  <= '0;
         hdr_q   <= 1'b0;
         tail_q  <= 1'b0;
         seq_q   <= '0;
         idx_q   <= '0;
         pcnt_q  <= '0;
         gap_q   <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         flit_q  <= flit_d;
         hdr_q   <= hdr_d;
         tail_q  <= tail_d;
         seq_q   <= seq_d;
         idx_q   <= idx_d;
         pcnt_q  <= pcnt_d;
         gap_q   <= gap_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
      end
   end

   assign tx_valid     = vld_q;
   assign tx_flit      = flit_q;
   assign tx_is_header = hdr_q;
   assign tx_is_tail   = tail_q;
   assign tx_pkt_cnt   = pcnt_q;
   assign send_busy    = (state_q == S_HDR) || (state_q == S_BODY) ||
                         (state_q == S_GAP);
   assign send_done    = (state_q == S_DONE);

   logic              act_q, act_d;
   logic [15:0]       eidx_q, eidx_d;
   logic [15:0]       eseq_q, eseq_d;
   logic              perr_q, perr_d;
   logic [15:0]       rcnt_q, rcnt_d;
   logic [15:0]       ecnt_q, ecnt_d;
   logic              err_q, err_d;
   logic              acc, ferr, hbad, good;
   logic [EW-1:0]     rx_ext;
   logic [ID_X_W-1:0] h_dx;
   logic [ID_Y_W-1:0] h_dy;
   logic [15:0]       h_seq;
   logic              unused_rx;

   assign rx_ready  = ~rx_stall;
   assign acc       = rx_valid & ~rx_stall;
   assign rx_ext    = EW'(rx_flit);
   assign h_dx      = rx_flit[ID_X_W-1:0];
   assign h_dy      = rx_flit[ID_X_W +: ID_Y_W];
   assign h_seq     = rx_flit[2*(ID_X_W+ID_Y_W) +: 16];
   assign unused_rx = ^rx_ext;

   always_comb begin
      act_d  = act_q;
      eidx_d = eidx_q;
      eseq_d = eseq_q;
      perr_d = perr_q;
      rcnt_d = rcnt_q;
      ecnt_d = ecnt_q;
      err_d  = err_q;
      ferr   = 1'b0;
      hbad   = 1'b0;
      good   = 1'b0;
      if (acc && rx_is_header) begin
         // a header mid-packet is an error, but the new packet starts clean
         hbad   = (h_dx != SX) || (h_dy != SY) ||
                  (rx_is_tail != (LAST == 16'd0));
         ferr   = hbad || act_q;
         eseq_d = h_seq;
         perr_d = hbad;
         eidx_d = 16'd1;
         act_d  = !(rx_is_tail || LAST == 16'd0);
         good   = !act_d && !hbad;
      end else if (acc && !act_q) begin
         ferr = 1'b1;
      end else if (acc) begin
         ferr   = (rx_ext[15:0] != eidx_q) ||
                  (rx_ext[31:16] != eseq_q) ||
                  (rx_is_tail != (eidx_q == LAST));
         perr_d = perr_q || ferr;
         eidx_d = eidx_q + 16'd1;
         if (rx_is_tail || eidx_q == LAST) begin
            act_d = 1'b0;
            good  = !(perr_q || ferr);
         end
      end
      if (ferr) begin
         err_d  = 1'b1;
         ecnt_d = (ecnt_q == 16'hFFFF) ? ecnt_q : ecnt_q + 16'd1;
      end
      if (good) begin
         rcnt_d = (rcnt_q == 16'hFFFF) ? rcnt_q : rcnt_q + 16'd1;
      end
   end

   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         act_q  <= 1'b0;
         eidx_q <= '0;
         eseq_q <= '0;
         perr_q <= 1'b0;
         rcnt_q <= '0;
         ecnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         act_q  <= act_d;
         eidx_q <= eidx_d;
         eseq_q <= eseq_d;
         perr_q <= perr_d;
         rcnt_q <= rcnt_d;
         ecnt_q <= ecnt_d;
         err_q  <= err_d;
      end
   end

   assign rx_pkt_cnt = rcnt_q;
   assign rx_err_cnt = ecnt_q;
   assign rx_err     = err_q;

endmodule

// File: tb/tb_noc_traffic_node.sv
// Bench for noc_traffic_node: default node in loopback/injection and a
// single-flit, gapped node; tx flits checked against a scoreboard.
module tb_noc_traffic_node;

   localparam int PL = 4;
   localparam int NP = 8;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        start_a, stall_a, rdy_a, loop_a, rnd_a;
   logic [3:0]  dx_a, dy_a;
   logic        inj_v, inj_h, inj_t;
   logic [31:0] inj_f;
   logic        rxv_a, rxr_a, rxh_a, rxt_a;
   logic [31:0] rxf_a, txf_a;
   logic        txv_a, txh_a, txt_a, busy_a, done_a, err_a;
   logic [15:0] tpc_a, rpc_a, rec_a;

   logic        start_b, rdy_b, rxr_b;
   logic [31:0] txf_b;
   logic        txv_b, txh_b, txt_b, busy_b, done_b, err_b;
   logic [15:0] tpc_b, rpc_b, rec_b;

   assign rxv_a = loop_a ? (txv_a & rdy_a) : inj_v;
   assign rxf_a = loop_a ? txf_a : inj_f;
   assign rxh_a = loop_a ? txh_a : inj_h;
   assign rxt_a = loop_a ? txt_a : inj_t;

   noc_traffic_node u_dut (
      .noc_clk(clk), .noc_rst(rst), .send_start(start_a),
      .dst_x(dx_a), .dst_y(dy_a), .rx_stall(stall_a),
      .rx_valid(rxv_a), .rx_ready(rxr_a), .rx_flit(rxf_a),
      .rx_is_header(rxh_a), .rx_is_tail(rxt_a),
      .tx_valid(txv_a), .tx_ready(rdy_a), .tx_flit(txf_a),
      .tx_is_header(txh_a), .tx_is_tail(txt_a),
      .send_busy(busy_a), .send_done(done_a),
      .tx_pkt_cnt(tpc_a), .rx_pkt_cnt(rpc_a),
      .rx_err_cnt(rec_a), .rx_err(err_a)
   );

   noc_traffic_node #(.PKT_LEN(1), .NUM_PKTS(3), .GAP_CYC(3)) u_gap (
      .noc_clk(clk), .noc_rst(rst), .send_start(start_b),
      .dst_x(4'd0), .dst_y(4'd0), .rx_stall(1'b0),
      .rx_valid(txv_b & rdy_b), .rx_ready(rxr_b), .rx_flit(txf_b),
      .rx_is_header(txh_b), .rx_is_tail(txt_b),
      .tx_valid(txv_b), .tx_ready(rdy_b), .tx_flit(txf_b),
      .tx_is_header(txh_b), .tx_is_tail(txt_b),
      .send_busy(busy_b), .send_done(done_b),
      .tx_pkt_cnt(tpc_b), .rx_pkt_cnt(rpc_b),
      .rx_err_cnt(rec_b), .rx_err(err_b)
   );

   int          n_run = 0;
   int          n_fail = 0;
   logic [33:0] qa[$];
   logic [33:0] qb[$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic        hold_a;
   logic [33:0] held_a;
   int          hs_a, idle_busy_a;
   always @(negedge clk) begin
      logic [33:0] e;
      if (rst) begin
         hold_a = 1'b0;
         idle_busy_a = 0;
      end else if (txv_a) begin
         if (hold_a) chk("hold_a", {txh_a, txt_a, txf_a}, held_a);
         if (rdy_a) begin
            hs_a++;
            if (qa.size() == 0) chk("extra_flit_a", 1, 0);
            else begin
               e = qa.pop_front();
               chk("flit_a", {txh_a, txt_a, txf_a}, e);
            end
         end
         hold_a = !rdy_a;
         held_a = {txh_a, txt_a, txf_a};
      end else begin
         if (hold_a) chk("valid_drop_a", 0, 1);
         hold_a = 1'b0;
         if (busy_a) idle_busy_a++;
      end
   end

   logic seen_tail_b, done_seen_b;
   int   idle_b, n_gap_b;
   always @(negedge clk) begin
      logic [33:0] e;
      if (rst) begin
         seen_tail_b = 1'b0;
         done_seen_b = 1'b0;
         idle_b = 0;
      end else if (txv_b) begin
         if (seen_tail_b) begin
            chk("gap_len", idle_b, 3);
            n_gap_b++;
         end
         seen_tail_b = 1'b0;
         if (qb.size() == 0) chk("extra_flit_b", 1, 0);
         else begin
            e = qb.pop_front();
            chk("flit_b", {txh_b, txt_b, txf_b}, e);
         end
         if (txt_b) begin
            seen_tail_b = 1'b1;
            idle_b = 0;
         end
      end else begin
         idle_b++;
         if (done_b && !done_seen_b) begin
            chk("done_after_tail", idle_b, 1);
            done_seen_b = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      rdy_a = rnd_a ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic push_a();
      for (int p = 0; p < NP; p++) begin
         for (int i = 0; i < PL; i++) begin
            if (i == 0)
               qa.push_back({1'b1, 1'b0, 16'(p), 8'h00, dy_a, dx_a});
            else
               qa.push_back({1'b0, (i == PL - 1), 16'(p), 16'(i)});
         end
      end
   endtask

   task automatic push_b();
      for (int p = 0; p < 3; p++) qb.push_back({2'b11, 16'(p), 16'h0});
   endtask

   task automatic start_a_t();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("start_lat_a", txv_a, 1);
   endtask

   task automatic wait_done(input bit sel, input int max);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < max && !ok; c++) begin
         if (sel ? done_b : done_a) ok = 1'b1;
         else tick();
      end
      chk(sel ? "timeout_b" : "timeout_a", ok, 1);
      tick();
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic chk_burst_a(input string tag);
      chk({tag, "_done"}, done_a, 1);
      chk({tag, "_tpc"}, tpc_a, NP);
      chk({tag, "_rpc"}, rpc_a, NP);
      chk({tag, "_rec"}, rec_a, 0);
      chk({tag, "_q"}, qa.size(), 0);
      chk({tag, "_b2b"}, idle_busy_a, 0);
   endtask

   initial begin
      int base, cnt;
      rst = 1'b1; start_a = 0; start_b = 0; stall_a = 0;
      rdy_a = 1; rdy_b = 1; loop_a = 1; rnd_a = 0;
      dx_a = 0; dy_a = 0; inj_v = 0; inj_h = 0; inj_t = 0; inj_f = 0;
      hs_a = 0; n_gap_b = 0;
      tick(); tick();
      chk("rst_valid", txv_a, 0);
      chk("rst_flit", txf_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_cnts", {tpc_a, rpc_a, rec_a, err_a}, 0);
      rst = 1'b0;
      tick();
      stall_a = 1'b1; #1;
      chk("rx_ready_stall", rxr_a, 0);
      stall_a = 1'b0; #1;
      chk("rx_ready_free", rxr_a, 1);

      push_a();
      start_a_t();
      wait_done(0, 300);
      chk_burst_a("b2b");

      pulse_rst();
      rnd_a = 1'b1;
      push_a();
      start_a_t();
      for (int k = 0; k < 6; k++) tick();
      dx_a = 4'd5; dy_a = 4'd5; start_a = 1'b1;
      tick();
      start_a = 1'b0; dx_a = 4'd0; dy_a = 4'd0;
      wait_done(0, 2000);
      chk_burst_a("rnd");
      rnd_a = 1'b0;

      push_b();
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("start_lat_b", txv_b, 1);
      wait_done(1, 300);
      chk("gap_tpc", tpc_b, 3);
      chk("gap_rpc", rpc_b, 3);
      chk("gap_rec", rec_b, 0);
      chk("gap_count", n_gap_b, 2);
      chk("gap_q", qb.size(), 0);

      loop_a = 1'b0;
      inj_v = 1; inj_h = 1; inj_t = 0; inj_f = 32'h0000_0001;
      tick();
      inj_h = 0; inj_f = 32'h0000_0002;
      tick();
      stall_a = 1'b1; inj_f = 32'h0000_0003;
      tick();
      inj_v = 0; stall_a = 1'b0;
      tick();
      chk("inj_rec", rec_a, 2);
      chk("inj_err", err_a, 1);
      chk("inj_rpc", rpc_a, NP);
      loop_a = 1'b1;

      push_a();
      base = hs_a;
      start_a_t();
      for (int c = 0; c < 200 && hs_a < base + PL + 2; c++) tick();
      chk("mid_reach", hs_a, base + PL + 2);
      rst = 1'b1; #1;
      chk("mrst_valid", txv_a, 0);
      chk("mrst_flags", {txh_a, txt_a, txf_a}, 0);
      chk("mrst_stat", {busy_a, done_a, err_a}, 0);
      chk("mrst_cnts", {tpc_a, rpc_a, rec_a}, 0);
      qa.delete();
      tick();
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (txv_a) cnt++;
      end
      chk("quiet_after_rst", cnt, 0);
      push_a();
      start_a_t();
      wait_done(0, 300);
      chk_burst_a("restart");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/noc_traffic_node.md
NOC_TRAFFIC_NODE -- requirements
Module: noc_traffic_node

Interface
REQ-001 Parameter X_ID, default 0, this node's X coordinate.
REQ-002 Parameter Y_ID, default 0, this node's Y coordinate.
REQ-003 Parameters ID_X_W / ID_Y_W, default 4 / 4, coordinate widths.
REQ-004 Parameter DATA_W, default 32, flit width; SHALL satisfy DATA_W >= 2*(ID_X_W+ID_Y_W)+16 (elaboration error otherwise).
REQ-005 Parameter PKT_LEN, default 4, flits per packet including header; legal range 1..65535.
REQ-006 Parameter NUM_PKTS, default 8, packets per burst; legal range 1..65535.
REQ-007 Parameter GAP_CYC, default 0, idle cycles inserted between packets.
REQ-008 Ports: noc_clk in 1 clock; noc_rst in 1 asynchronous active-high reset.
REQ-009 send_start in 1, burst start request; dst_x in ID_X_W and dst_y in ID_Y_W, burst destination; rx_stall in 1, receive back-pressure.
REQ-010 Receive side: rx_valid in 1; rx_ready out 1; rx_flit in DATA_W; rx_is_header in 1; rx_is_tail in 1.
REQ-011 Send side: tx_valid out 1; tx_ready in 1; tx_flit out DATA_W; tx_is_header out 1; tx_is_tail out 1.
REQ-012 Status: send_busy out 1; send_done out 1; tx_pkt_cnt out 16; rx_pkt_cnt out 16; rx_err_cnt out 16; rx_err out 1 (sticky).

Function
REQ-013 Header flit layout, LSB first: dst_x, dst_y, src_x(=X_ID), src_y(=Y_ID), 16-bit seq; bits above zero.
REQ-014 Body flit i (1..PKT_LEN-1) SHALL carry {seq[15:0], i[15:0]} in bits [31:0], bits above zero.
REQ-015 PKT_LEN=1: the single flit SHALL have tx_is_header=tx_is_tail=1.
REQ-016 Sender FSM states IDLE, HDR, BODY, GAP, DONE.
REQ-017 IDLE/DONE + send_start=1 -> HDR; dst_x/dst_y latched; seq, flit index, tx_pkt_cnt cleared; send_done cleared.
REQ-018 tx_valid SHALL assert the cycle after send_start is sampled; flit and flags registered and held stable until tx_valid&&tx_ready.
REQ-019 tx_valid SHALL never deassert before handshake; handshake advances one flit per cycle under continuous tx_ready.
REQ-020 HDR handshake -> BODY (or tail handling if PKT_LEN=1); tx_is_tail=1 only on flit PKT_LEN-1.
REQ-021 Tail handshake: tx_pkt_cnt++, seq++; if tx_pkt_cnt reaches NUM_PKTS -> DONE, else GAP_CYC=0 -> HDR next cycle, else GAP for exactly GAP_CYC cycles with tx_valid=0, then HDR.
REQ-022 send_busy=1 in HDR/BODY/GAP; send_done=1 in DONE; send_start ignored while busy.
REQ-023 rx_ready SHALL equal ~rx_stall (combinational); a flit is accepted only when rx_valid&&rx_ready.
REQ-024 Checker tracks expected index and packet seq; header accepted while idle SHALL start a packet, latching seq.
REQ-025 Error events (each +1 rx_err_cnt, sets rx_err): header dst != (X_ID,Y_ID); body index or seq mismatch; tail on wrong index or missing on index PKT_LEN-1; header mid-packet (packet restarts from this header); body flit while idle (discarded).
REQ-026 Tail accepted at expected index with no error in the packet SHALL increment rx_pkt_cnt.
REQ-027 All counters 16-bit, saturating at 0xFFFF.
REQ-028 Multiple error conditions on one flit count as one error.

Reset
REQ-029 noc_rst=1 SHALL immediately force: FSM IDLE, tx_valid=0, tx_flit=0, tx_is_header=0, tx_is_tail=0, send_busy=0, send_done=0, all counters 0, rx_err=0, checker idle.
REQ-030 Reset mid-packet SHALL abandon the packet; after release, no flit is emitted until a new send_start.
REQ-031 Only reset clears rx_err and rx_err_cnt.

Verification
REQ-032 Defaults, X_ID=Y_ID=0, tx looped to rx, dst=(0,0), tx_ready=1, pulse send_start -> 32 flits back-to-back, send_done=1, tx_pkt_cnt=8, rx_pkt_cnt=8, rx_err_cnt=0.
REQ-033 tx_ready random 50% -> tx_flit/flags stable while tx_valid&&!tx_ready; identical counts as REQ-032.
REQ-034 GAP_CYC=3 -> exactly 3 tx_valid=0 cycles between each tail and next header; none after last tail.
REQ-035 Inject header dst=(1,0), then body flit with index 2 instead of 1 -> rx_err_cnt=2, rx_err=1, rx_pkt_cnt unchanged.
REQ-036 PKT_LEN=1, NUM_PKTS=3 -> three flits with header=tail=1, seq 0,1,2; tx_pkt_cnt=3.
REQ-037 Assert noc_rst during BODY of packet 2 -> outputs at reset values same cycle; no tx_valid until next send_start, which restarts at seq 0.
